// File: rtl/mmcm_drp_sequencer.sv
// MMCM DRP sequencer: read-modify-writes a per-profile register table under MMCM reset, then
// waits for lock; also reads back one DRP word. Build macro DRP_READBACK_VERIFY_EN adds re-read checks.
module mmcm_drp_sequencer #(
   parameter int unsigned NUM_REGS     = 4,
   parameter int unsigned DRDY_TIMEOUT = 64,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter logic [6:0]  RB_ADDR      = 7'h08
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        write_enable,
   input  logic        read_enable,
   input  logic        profile_sel,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [6:0]  drp_daddr,
   output logic [15:0] drp_di,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic        mmcm_rst,
   input  logic        mmcm_locked,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  led
);

   localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned MaxT = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int unsigned CntW = $clog2(MaxT + 1);
   // DRDY budget is measured from the den cycle, which precedes the wait-state entry by one cycle.
   localparam logic [CntW-1:0] DrdyLimit = CntW'(DRDY_TIMEOUT - 2);
   localparam logic [CntW-1:0] LockLimit = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_REGS - 1);

   typedef struct packed {
      logic [6:0]  addr;
      logic [15:0] mask;
      logic [15:0] bits;
   } tbl_entry_t;

   typedef enum logic [3:0] {
      StIdle,
      StRstAssert,
      StRdReq,
      StRdWait,
      StModify,
      StWrReq,
      StWrWait,
      StLockWait,
      StDone,
      StRbReq,
      StRbWait
`ifdef DRP_READBACK_VERIFY_EN
      ,
      StVfyReq,
      StVfyWait
`endif
   } state_e;

   function automatic tbl_entry_t tbl_lookup(input logic prof, input logic [IdxW-1:0] i);
      tbl_entry_t e;
      e = '{addr: 7'h00, mask: 16'hFFFF, bits: 16'h0000};
      case (int'(i))
         0: begin
            if (prof) e = '{addr: 7'h08, mask: 16'h1000, bits: 16'h00C2};
            else      e = '{addr: 7'h08, mask: 16'h1000, bits: 16'h0145};
         end
         1: begin
            if (prof) e = '{addr: 7'h09, mask: 16'hFC00, bits: 16'h0080};
            else      e = '{addr: 7'h09, mask: 16'hFC00, bits: 16'h0000};
         end
         2: e = '{addr: 7'h14, mask: 16'h1000, bits: 16'h0145};
         3: e = '{addr: 7'h15, mask: 16'hFC00, bits: 16'h0000};
         default: e = '{addr: 7'h00, mask: 16'hFFFF, bits: 16'h0000};
      endcase
      return e;
   endfunction

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [15:0]       rd_data_q, rd_data_d;
   logic [15:0]       new_q, new_d;
   logic              profile_q, profile_d;
   logic              err_q, err_d;
   logic [7:0]        led_q, led_d;
   logic              we_prev_q, re_prev_q;

   tbl_entry_t cur;
   logic       we_rise, re_rise;
   logic       drdy_expired, lock_expired, last_entry;

   assign cur          = tbl_lookup(profile_q, idx_q);
   assign we_rise      = write_enable & ~we_prev_q;
   assign re_rise      = read_enable & ~re_prev_q;
   assign drdy_expired = (cnt_q == DrdyLimit);
   assign lock_expired = (cnt_q == LockLimit);
   assign last_entry   = (idx_q == LastIdx);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         cnt_q     <= '0;
         rd_data_q <= '0;
         new_q     <= '0;
         profile_q <= 1'b0;
         err_q     <= 1'b0;
         led_q     <= '0;
         we_prev_q <= 1'b0;
         re_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         new_q     <= new_d;
         profile_q <= profile_d;
         err_q     <= err_d;
         led_q     <= led_d;
         we_prev_q <= write_enable;
         re_prev_q <= read_enable;
      end
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (state_d != state_q || state_q == StIdle) cnt_d = '0;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rd_data_d = rd_data_q;
      new_d     = new_q;
      profile_d = profile_q;
      err_d     = err_q;
      led_d     = led_q;
      unique case (state_q)
         StIdle: begin
            // Reconfiguration takes priority over a simultaneous readback request.
            if (we_rise) begin
               state_d   = StRstAssert;
               profile_d = profile_sel;
               idx_d     = '0;
               err_d     = 1'b0;
            end else if (re_rise) begin
               state_d = StRbReq;
               err_d   = 1'b0;
            end
         end
         StRstAssert: begin
            idx_d   = '0;
            state_d = StRdReq;
         end
         StRdReq: state_d = StRdWait;
         StRdWait: begin
            if (drp_drdy) begin
               rd_data_d = drp_do;
               state_d   = StModify;
            end else if (drdy_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StModify: begin
            new_d   = (rd_data_q & cur.mask) | cur.bits;
            state_d = StWrReq;
         end
         StWrReq: state_d = StWrWait;
         StWrWait: begin
            if (drp_drdy) begin
`ifdef DRP_READBACK_VERIFY_EN
               state_d = StVfyReq;
`else
               if (last_entry) begin
                  state_d = StLockWait;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StRdReq;
               end
`endif
            end else if (drdy_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
`ifdef DRP_READBACK_VERIFY_EN
         StVfyReq: state_d = StVfyWait;
         StVfyWait: begin
            if (drp_drdy) begin
               if (drp_do != new_q) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else if (last_entry) begin
                  state_d = StLockWait;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StRdReq;
               end
            end else if (drdy_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
`endif
         StLockWait: begin
            if (mmcm_locked) begin
               state_d = StDone;
            end else if (lock_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         StDone: state_d = StIdle;
         StRbReq: state_d = StRbWait;
         StRbWait: begin
            if (drp_drdy) begin
               led_d   = drp_do[7:0];
               state_d = StDone;
            end else if (drdy_expired) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // mmcm_rst is a pure state decode, so every path back to idle releases it.
   always_comb begin
      drp_den   = 1'b0;
      drp_dwe   = 1'b0;
      drp_daddr = '0;
      drp_di    = '0;
      mmcm_rst  = 1'b0;
      unique case (state_q)
         StRstAssert, StRdWait, StModify, StWrWait: mmcm_rst = 1'b1;
         StRdReq: begin
            mmcm_rst  = 1'b1;
            drp_den   = 1'b1;
            drp_daddr = cur.addr;
         end
         StWrReq: begin
            mmcm_rst  = 1'b1;
            drp_den   = 1'b1;
            drp_dwe   = 1'b1;
            drp_daddr = cur.addr;
            drp_di    = new_q;
         end
`ifdef DRP_READBACK_VERIFY_EN
         StVfyReq: begin
            mmcm_rst  = 1'b1;
            drp_den   = 1'b1;
            drp_daddr = cur.addr;
         end
         StVfyWait: mmcm_rst = 1'b1;
`endif
         StRbReq: begin
            drp_den   = 1'b1;
            drp_daddr = RB_ADDR;
         end
         default: ;
      endcase
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign err  = err_q;
   assign led  = led_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: DRP/MMCM behavioural models plus a table-driven expected-value model.
module tb_mmcm_drp_sequencer;

   localparam int unsigned DrdyTo = 64;
   localparam int unsigned LockTo = 300;
`ifdef DRP_READBACK_VERIFY_EN
   localparam int DensPerEntry = 3;
`else
   localparam int DensPerEntry = 2;
`endif

   localparam logic [6:0]  TAddr [4] = '{7'h08, 7'h09, 7'h14, 7'h15};
   localparam logic [15:0] TMask [4] = '{16'h1000, 16'hFC00, 16'h1000, 16'hFC00};
   localparam logic [15:0] TBits [2][4] = '{'{16'h0145, 16'h0000, 16'h0145, 16'h0000},
                                            '{16'h00C2, 16'h0080, 16'h0145, 16'h0000}};

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        write_enable = 1'b0;
   logic        read_enable = 1'b0;
   logic        profile_sel = 1'b0;
   logic        drp_den, drp_dwe;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di;
   logic [15:0] drp_do = '0;
   logic        drp_drdy = 1'b0;
   logic        mmcm_rst;
   logic        mmcm_locked = 1'b0;
   logic        busy, done, err;
   logic [7:0]  led;

   int compared = 0;
   int mismatched = 0;

   mmcm_drp_sequencer #(
      .NUM_REGS    (4),
      .DRDY_TIMEOUT(DrdyTo),
      .LOCK_TIMEOUT(LockTo),
      .RB_ADDR     (7'h08)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .write_enable(write_enable),
      .read_enable (read_enable),
      .profile_sel (profile_sel),
      .drp_den     (drp_den),
      .drp_dwe     (drp_dwe),
      .drp_daddr   (drp_daddr),
      .drp_di      (drp_di),
      .drp_do      (drp_do),
      .drp_drdy    (drp_drdy),
      .mmcm_rst    (mmcm_rst),
      .mmcm_locked (mmcm_locked),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .led         (led)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // DRP register file model: drdy one cycle after den, optional bit0 corruption on writes.
   logic [15:0] mem [128];
   bit          drdy_en = 1'b1;
   bit          corrupt = 1'b0;
   bit          pre_we = 1'b0;
   logic [6:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;
   always @(posedge sys_clk) begin
      drp_drdy <= 1'b0;
      if (pre_we) mem[pre_addr] <= pre_data;
      if (drp_den && drdy_en) begin
         drp_drdy <= 1'b1;
         if (drp_dwe) mem[drp_daddr] <= drp_di ^ {15'b0, corrupt};
         else drp_do <= mem[drp_daddr];
      end
   end

   // MMCM lock model: lock_delay cycles after reset release, unless lock_never.
   int lock_delay = 100;
   bit lock_never = 1'b0;
   int lock_cnt = 0;
   always @(posedge sys_clk) begin
      if (mmcm_rst || lock_never) begin
         lock_cnt    <= 0;
         mmcm_locked <= 1'b0;
      end else if (lock_cnt >= lock_delay) begin
         mmcm_locked <= 1'b1;
      end else begin
         lock_cnt <= lock_cnt + 1;
      end
   end

   // Bus monitor: event counts, write log and DRP protocol violations.
   int          n_den = 0, n_dwe = 0, n_done = 0, n_proto = 0;
   bit          den_prev = 1'b0, pending = 1'b0;
   logic [6:0]  wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   bit          wr_rst_q [$];
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         den_prev <= 1'b0;
         pending  <= 1'b0;
      end else begin
         if (drp_dwe && !drp_den) n_proto <= n_proto + 1;
         if (drp_den && (den_prev || pending)) n_proto <= n_proto + 1;
         if (drp_den) pending <= 1'b1;
         else if (drp_drdy || !busy) pending <= 1'b0;
         den_prev <= drp_den;
         if (drp_den) n_den <= n_den + 1;
         if (drp_dwe) n_dwe <= n_dwe + 1;
         if (done) n_done <= n_done + 1;
         if (drp_den && drp_dwe) begin
            wr_addr_q.push_back(drp_daddr);
            wr_data_q.push_back(drp_di);
            wr_rst_q.push_back(mmcm_rst);
         end
      end
   end

   task automatic mem_load(input logic [6:0] a, input logic [15:0] d);
      @(negedge sys_clk);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge sys_clk);
      pre_we = 1'b0;
   endtask

   task automatic start_write(input bit prof);
      @(negedge sys_clk);
      profile_sel  = prof;
      write_enable = 1'b1;
      @(negedge sys_clk);
      write_enable = 1'b0;
   endtask

   task automatic start_read();
      @(negedge sys_clk);
      read_enable = 1'b1;
      @(negedge sys_clk);
      read_enable = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit timed_out);
      int n;
      n = 0;
      @(negedge sys_clk);
      while (busy && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      timed_out = busy;
   endtask

   task automatic run_reconfig_check(input bit prof, input int lock_dly);
      logic [15:0] expv [4];
      int w0, d0, p0;
      bit to;
      lock_delay = lock_dly;
      for (int i = 0; i < 4; i++) expv[i] = (mem[TAddr[i]] & TMask[i]) | TBits[prof][i];
      w0 = wr_addr_q.size();
      d0 = n_done;
      p0 = n_proto;
      start_write(prof);
      compared++;
      if (err !== 1'b0) begin
         mismatched++;
         $display("FAIL err_cleared_on_start: got %b want 0", err);
      end
      wait_idle(2000, to);
      compared++;
      if (to) begin
         mismatched++;
         $display("FAIL reconfig_timeout: still busy after budget");
      end
      compared++;
      if (n_done - d0 !== 1) begin
         mismatched++;
         $display("FAIL reconfig_done_count: got %0d want 1", n_done - d0);
      end
      compared++;
      if (err !== 1'b0) begin
         mismatched++;
         $display("FAIL reconfig_err: got %b want 0", err);
      end
      compared++;
      if (wr_addr_q.size() - w0 !== 4) begin
         mismatched++;
         $display("FAIL reconfig_write_count: got %0d want 4", wr_addr_q.size() - w0);
      end
      for (int i = 0; i < 4; i++) begin
         if (w0 + i < wr_addr_q.size()) begin
            compared++;
            if ({wr_addr_q[w0+i], wr_data_q[w0+i], wr_rst_q[w0+i]} !== {TAddr[i], expv[i], 1'b1}) begin
               mismatched++;
               $display("FAIL reconfig_write%0d: got addr %h data %h rst %b want addr %h data %h rst 1",
                        i, wr_addr_q[w0+i], wr_data_q[w0+i], wr_rst_q[w0+i], TAddr[i], expv[i]);
            end
         end
         compared++;
         if (mem[TAddr[i]] !== expv[i]) begin
            mismatched++;
            $display("FAIL reconfig_mem%0d: got %h want %h", i, mem[TAddr[i]], expv[i]);
         end
      end
      compared++;
      if (n_proto !== p0) begin
         mismatched++;
         $display("FAIL drp_protocol: got %0d violations want 0", n_proto - p0);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      compared++;
      if ({drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst, busy, done, err, led} !== '0) begin
         mismatched++;
         $display("FAIL %s: got den %b dwe %b addr %h di %h rst %b busy %b done %b err %b led %h want all 0",
                  tag, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst, busy, done, err, led);
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_outputs_zero("reset_asserted");
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      check_outputs_zero("reset_released");
      for (int i = 0; i < 4; i++) mem_load(TAddr[i], 16'($urandom));
   endtask

   task automatic test_reconfig_directed();
      mem_load(7'h08, 16'h1FFF);
      run_reconfig_check(1'b1, 100);
      compared++;
      if (mem[7'h08] !== 16'h10C2) begin
         mismatched++;
         $display("FAIL reconfig_reg08: got %h want 10c2", mem[7'h08]);
      end
   endtask

   task automatic test_reconfig_random();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) mem_load(TAddr[i], 16'($urandom));
         run_reconfig_check(1'($urandom_range(0, 1)), int'($urandom_range(5, 150)));
      end
   endtask

   task automatic test_readback(input logic [15:0] val);
      int d0, w0;
      bit to;
      mem_load(7'h08, val);
      d0 = n_done;
      w0 = n_dwe;
      start_read();
      wait_idle(200, to);
      compared++;
      if (to || led !== val[7:0]) begin
         mismatched++;
         $display("FAIL readback_led: got %h want %h (timeout %b)", led, val[7:0], to);
      end
      compared++;
      if (n_done - d0 !== 1 || n_dwe !== w0) begin
         mismatched++;
         $display("FAIL readback_done_dwe: got done %0d dwe %0d want 1 and 0", n_done - d0, n_dwe - w0);
      end
   endtask

   task automatic test_drdy_timeout();
      int den_cyc, err_cyc, d0, n;
      den_cyc = -1;
      err_cyc = -1;
      drdy_en = 1'b0;
      d0 = n_done;
      start_write(1'b0);
      n = 0;
      while (!drp_den && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      if (drp_den) den_cyc = cyc;
      n = 0;
      while (!err && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      if (err) err_cyc = cyc;
      compared++;
      if (den_cyc < 0 || err_cyc < 0 || err_cyc - den_cyc !== int'(DrdyTo)) begin
         mismatched++;
         $display("FAIL drdy_timeout_latency: got %0d cycles want %0d", err_cyc - den_cyc, DrdyTo);
      end
      compared++;
      if ({mmcm_rst, busy} !== 2'b00 || n_done !== d0) begin
         mismatched++;
         $display("FAIL drdy_timeout_state: got rst %b busy %b done %0d want 0 0 0",
                  mmcm_rst, busy, n_done - d0);
      end
      drdy_en = 1'b1;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_lock_timeout();
      int fall_cyc, err_cyc, d0, n;
      bit prev_rst;
      fall_cyc = -1;
      err_cyc = -1;
      lock_never = 1'b1;
      d0 = n_done;
      start_write(1'($urandom_range(0, 1)));
      prev_rst = mmcm_rst;
      n = 0;
      while (!err && n < int'(LockTo) + 300) begin
         @(negedge sys_clk);
         if (prev_rst && !mmcm_rst && fall_cyc < 0) fall_cyc = cyc;
         prev_rst = mmcm_rst;
         n++;
      end
      if (err) err_cyc = cyc;
      compared++;
      if (fall_cyc < 0 || err_cyc < 0 || err_cyc - fall_cyc !== int'(LockTo)) begin
         mismatched++;
         $display("FAIL lock_timeout_latency: got %0d cycles want %0d", err_cyc - fall_cyc, LockTo);
      end
      compared++;
      if ({mmcm_rst, busy} !== 2'b00 || n_done !== d0) begin
         mismatched++;
         $display("FAIL lock_timeout_state: got rst %b busy %b done %0d want 0 0 0",
                  mmcm_rst, busy, n_done - d0);
      end
      lock_never = 1'b0;
      run_reconfig_check(1'($urandom_range(0, 1)), 40);
   endtask

   task automatic test_back_to_back();
      logic [15:0] expv [4];
      logic [7:0] led0;
      int den0, d0, w0;
      bit to;
      for (int i = 0; i < 4; i++) expv[i] = (mem[TAddr[i]] & TMask[i]) | TBits[0][i];
      led0 = led;
      den0 = n_den;
      d0 = n_done;
      w0 = wr_addr_q.size();
      lock_delay = 30;
      @(negedge sys_clk);
      profile_sel  = 1'b0;
      write_enable = 1'b1;
      read_enable  = 1'b1;
      @(negedge sys_clk);
      write_enable = 1'b0;
      read_enable  = 1'b0;
      repeat (3) begin
         @(negedge sys_clk);
         write_enable = 1'b1;
         read_enable  = 1'b1;
         @(negedge sys_clk);
         write_enable = 1'b0;
         read_enable  = 1'b0;
      end
      wait_idle(2000, to);
      compared++;
      if (to || n_done - d0 !== 1) begin
         mismatched++;
         $display("FAIL b2b_done_count: got %0d want 1 (timeout %b)", n_done - d0, to);
      end
      compared++;
      if (n_den - den0 !== 4 * DensPerEntry || wr_addr_q.size() - w0 !== 4) begin
         mismatched++;
         $display("FAIL b2b_den_count: got den %0d writes %0d want %0d and 4",
                  n_den - den0, wr_addr_q.size() - w0, 4 * DensPerEntry);
      end
      compared++;
      if (led !== led0) begin
         mismatched++;
         $display("FAIL b2b_no_readback: got led %h want %h", led, led0);
      end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (mem[TAddr[i]] !== expv[i]) begin
            mismatched++;
            $display("FAIL b2b_mem%0d: got %h want %h", i, mem[TAddr[i]], expv[i]);
         end
      end
   endtask

   task automatic test_midreset();
      int k, n;
      k = 0;
      n = 0;
      start_write(1'($urandom_range(0, 1)));
      while (k < 3 && n < 100) begin
         if (drp_dwe) k++;
         if (k < 3) begin
            @(negedge sys_clk);
            n++;
         end
      end
      compared++;
      if (k !== 3) begin
         mismatched++;
         $display("FAIL midreset_reach_entry2: got %0d writes want 3", k);
      end
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check_outputs_zero("midreset_outputs");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      run_reconfig_check(1'($urandom_range(0, 1)), 20);
   endtask

   task automatic test_verify();
      logic [15:0] expv [4];
      int d0, w0;
      bit to;
      for (int i = 0; i < 4; i++) expv[i] = (mem[TAddr[i]] & TMask[i]) | TBits[1][i];
      corrupt = 1'b1;
      lock_delay = 20;
      d0 = n_done;
      w0 = wr_addr_q.size();
      start_write(1'b1);
      wait_idle(2000, to);
`ifdef DRP_READBACK_VERIFY_EN
      compared++;
      if (to || {err, mmcm_rst, busy} !== 3'b100 || n_done !== d0) begin
         mismatched++;
         $display("FAIL verify_mismatch: got err %b rst %b busy %b done %0d want 1 0 0 0",
                  err, mmcm_rst, busy, n_done - d0);
      end
      compared++;
      if (wr_addr_q.size() - w0 !== 1) begin
         mismatched++;
         $display("FAIL verify_stop: got %0d writes want 1", wr_addr_q.size() - w0);
      end
`else
      compared++;
      if (to || err !== 1'b0 || n_done - d0 !== 1) begin
         mismatched++;
         $display("FAIL noverify_done: got err %b done %0d want 0 1", err, n_done - d0);
      end
      for (int i = 0; i < 4; i++) begin
         compared++;
         if (mem[TAddr[i]] !== (expv[i] ^ 16'h0001)) begin
            mismatched++;
            $display("FAIL noverify_mem%0d: got %h want %h", i, mem[TAddr[i]], expv[i] ^ 16'h0001);
         end
      end
`endif
      corrupt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reconfig_directed();
      test_reconfig_random();
      for (int k = 0; k < 3; k++) test_readback(16'($urandom));
      test_readback(16'h10C2);
      test_drdy_timeout();
      test_lock_timeout();
      test_back_to_back();
      test_midreset();
      test_verify();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

endmodule
